// File: rtl/cache_pkg.sv
// Shared types and line-geometry helpers for the cache refill engine.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } refill_state_t;

    function automatic int word_off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int byte_off_w(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    localparam int WORD_OFF_W = word_off_w(4);
    localparam int BYTE_OFF_W = byte_off_w(32);

endpackage

// File: rtl/cache_refill_wrapctr.sv
// Loadable modulo-LINE_WORDS word offset plus a beat counter flagging the final beat.
module cache_refill_wrapctr
    import cache_pkg::*;
#(
    parameter  int LINE_WORDS = 4,
    localparam int OW         = word_off_w(LINE_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic [OW-1:0] load_off_i,
    input  logic          adv_i,
    output logic [OW-1:0] off_o,
    output logic          last_o
);

    logic [OW-1:0] off_q, off_d;
    logic [OW-1:0] cnt_q, cnt_d;

    // LINE_WORDS is a power of two, so natural overflow gives the wrap.
    always_comb begin
        off_d = off_q;
        cnt_d = cnt_q;
        if (load_i) begin
            off_d = load_off_i;
            cnt_d = '0;
        end else if (adv_i) begin
            off_d = off_q + OW'(1);
            cnt_d = cnt_q + OW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            off_q <= '0;
            cnt_q <= '0;
        end else begin
            off_q <= off_d;
            cnt_q <= cnt_d;
        end
    end

    assign off_o  = off_q;
    assign last_o = (cnt_q == OW'(LINE_WORDS - 1));

endmodule

// File: rtl/cache_refill.sv
// Line refill engine: one beat outstanding, done_o LINE_WORDS+1 cycles after accept with zero-wait memory.
// Memory stalls hold mem_addr_o; requests wait in FETCH/DONE. CACHE_REFILL_CWF_EN enables critical word first.
module cache_refill
    import cache_pkg::*;
#(
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    parameter  int LINE_WORDS = 4,
    localparam int OW         = word_off_w(LINE_WORDS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_vld_i,
    output logic                  req_rdy_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    output logic                  mem_stb_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_ack_i,
    input  logic                  mem_err_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic                  fill_we_o,
    output logic [OW-1:0]         fill_idx_o,
    output logic [DATA_WIDTH-1:0] fill_data_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int BW = byte_off_w(DATA_WIDTH);
    localparam int LB = OW + BW;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'((64'd1 << LB) - 64'd1);

    refill_state_t         state_q, state_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  ctr_load, ctr_adv, ctr_last;
    logic [OW-1:0]         off, start_off;

`ifdef CACHE_REFILL_CWF_EN
    assign start_off = req_addr_i[BW +: OW];
`else
    assign start_off = '0;
`endif

    cache_refill_wrapctr #(
        .LINE_WORDS (LINE_WORDS)
    ) u_wrapctr (
        .clk        (clk),
        .reset      (reset),
        .load_i     (ctr_load),
        .load_off_i (start_off),
        .adv_i      (ctr_adv),
        .off_o      (off),
        .last_o     (ctr_last)
    );

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        addr_d   = addr_q;
        ctr_load = 1'b0;
        ctr_adv  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_vld_i) begin
                    addr_d   = req_addr_i;
                    err_d    = 1'b0;
                    ctr_load = 1'b1;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                // An error wins over a simultaneous ack and ends the refill.
                if (mem_err_i) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (mem_ack_i) begin
                    ctr_adv = 1'b1;
                    if (ctr_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
        end
    end

    // Outputs are forced quiet while reset is held, even mid-refill.
    assign req_rdy_o   = reset || (state_q == IDLE);
    assign mem_stb_o   = !reset && (state_q == FETCH);
    assign mem_addr_o  = (addr_q & ~LINE_MASK) | (ADDR_WIDTH'(off) << BW);
    assign fill_we_o   = mem_stb_o && mem_ack_i && !mem_err_i;
    assign fill_idx_o  = off;
    assign fill_data_o = mem_data_i;
    assign done_o      = !reset && (state_q == DONE) && !err_q;
    assign err_o       = !reset && (state_q == DONE) && err_q;

endmodule

// File: tb/tb_cache_refill.sv
// Directed bench for cache_refill with a per-cycle reference model of the refill rules.
module tb_cache_refill;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 4;
`ifdef CACHE_REFILL_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_vld = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic          mem_ack = 1'b0;
    logic          mem_err = 1'b0;
    logic [DW-1:0] mem_data = '0;
    logic          req_rdy_o, mem_stb_o, fill_we_o, done_o, err_o;
    logic [AW-1:0] mem_addr_o;
    logic [1:0]    fill_idx_o;
    logic [DW-1:0] fill_data_o;

    cache_refill #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_vld_i   (req_vld),
        .req_rdy_o   (req_rdy_o),
        .req_addr_i  (req_addr),
        .mem_stb_o   (mem_stb_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ack_i   (mem_ack),
        .mem_err_i   (mem_err),
        .mem_data_i  (mem_data),
        .fill_we_o   (fill_we_o),
        .fill_idx_o  (fill_idx_o),
        .fill_data_o (fill_data_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Memory responder: acks after wait_cfg idle cycles, optional error on beat err_beat.
    int wait_cfg = 0, err_beat = 0, rsp_beat = 0, wcnt = 0;
    bit stray_ack = 1'b0;
    always @(posedge clk) begin
        #2;
        if (mem_stb_o) begin
            if (wcnt >= wait_cfg) begin
                rsp_beat++;
                mem_ack  = 1'b1;
                mem_err  = (rsp_beat == err_beat);
                mem_data = {~mem_addr_o[15:0], mem_addr_o[15:0]};
                wcnt     = 0;
            end else begin
                mem_ack = 1'b0;
                mem_err = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack  = stray_ack;
            mem_err  = stray_ack;
            mem_data = 32'hDEAD_BEEF;
            wcnt     = 0;
        end
    end

    // Reference model: refill in progress, beats acked so far, line base, start word.
    bit            m_busy = 0, m_fin = 0, m_err = 0;
    int            m_beats = 0, m_start = 0, m_acc = 0;
    logic [AW-1:0] m_base = '0;
    int            cyc = 0, acc_cyc = 0, done_cyc = 0;
    int            we_cnt = 0, done_cnt = 0, err_cnt = 0;
    logic [AW-1:0] addr_log[$];
    int            idx_log[$];
    bit            prev_stb = 0, prev_ack = 0, prev_err = 0;
    logic [AW-1:0] prev_addr = '0;
    logic [AW-1:0] exp_addr;
    bit            exp_stb, exp_we;

    always @(negedge clk) begin
        cyc++;
        exp_stb = !reset && m_busy;
        exp_we  = exp_stb && mem_ack && !mem_err;
        chk("req_rdy", req_rdy_o, reset || (!m_busy && !m_fin));
        chk("mem_stb", mem_stb_o, exp_stb);
        chk("fill_we", fill_we_o, exp_we);
        chk("done", done_o, !reset && m_fin && !m_err);
        chk("err", err_o, !reset && m_fin && m_err);
        if (exp_stb) begin
            exp_addr = m_base + AW'(((m_start + m_beats) % LW) * (DW / 8));
            chk("mem_addr", mem_addr_o, exp_addr);
        end
        if (exp_we) begin
            chk("fill_idx", fill_idx_o, (m_start + m_beats) % LW);
            chk("fill_data", fill_data_o, mem_data);
        end
        if (!reset && prev_stb && mem_stb_o && !prev_ack && !prev_err)
            chk("addr_hold", mem_addr_o, prev_addr);

        if (fill_we_o) begin
            we_cnt++;
            addr_log.push_back(mem_addr_o);
            idx_log.push_back(int'(fill_idx_o));
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err_o) err_cnt++;

        prev_stb  = mem_stb_o && !reset;
        prev_ack  = mem_ack;
        prev_err  = mem_err;
        prev_addr = mem_addr_o;

        if (reset) begin
            m_busy = 0; m_fin = 0; m_err = 0;
        end else if (m_fin) begin
            m_fin = 0;
        end else if (m_busy) begin
            if (mem_err) begin
                m_err = 1; m_busy = 0; m_fin = 1;
            end else if (mem_ack) begin
                m_beats++;
                if (m_beats == LW) begin
                    m_busy = 0; m_fin = 1;
                end
            end
        end else if (req_vld) begin
            m_busy  = 1;
            m_err   = 0;
            m_beats = 0;
            m_base  = req_addr & ~AW'(LW * DW / 8 - 1);
            m_start = CWF ? int'(req_addr[3:2]) : 0;
            m_acc++;
            acc_cyc = cyc;
        end
    end

    task automatic clear_logs();
        addr_log.delete();
        idx_log.delete();
        we_cnt = 0; done_cnt = 0; err_cnt = 0;
    endtask

    task automatic wait_end(input int budget);
        int i;
        for (i = 0; i < budget && (done_cnt + err_cnt) == 0; i++) begin
            @(negedge clk);
            #1;
        end
        if ((done_cnt + err_cnt) == 0) chk("refill_timeout", 0, 1);
    endtask

    task automatic run_refill(input logic [AW-1:0] a, input int w, input int eb);
        clear_logs();
        wait_cfg = w; err_beat = eb; rsp_beat = 0;
        @(posedge clk); #1;
        req_vld = 1'b1; req_addr = a;
        @(posedge clk); #1;
        req_vld = 1'b0;
        wait_end(200);
    endtask

    task automatic chk_addrs(input string nm, input logic [AW-1:0] e0, input logic [AW-1:0] e1,
                             input logic [AW-1:0] e2, input logic [AW-1:0] e3);
        logic [AW-1:0] ex[4];
        ex = '{e0, e1, e2, e3};
        chk({nm, "_beats"}, addr_log.size(), 4);
        for (int i = 0; i < 4; i++)
            chk({nm, "_addr"}, (i < addr_log.size()) ? addr_log[i] : 32'hFFFF_FFFF, ex[i]);
    endtask

    task automatic chk_idx(input string nm, input int e0, input int e1, input int e2, input int e3);
        int ex[4];
        ex = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++)
            chk({nm, "_idx"}, (i < idx_log.size()) ? idx_log[i] : -1, ex[i]);
    endtask

    initial begin
        int i;
        int acc0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk); #1;
        chk("post_reset_rdy", req_rdy_o, 1);
        chk("post_reset_stb", mem_stb_o, 0);

        // Stray ack/err while idle must not write or start anything.
        clear_logs();
        stray_ack = 1'b1;
        repeat (3) @(negedge clk);
        #1 stray_ack = 1'b0;
        chk("stray_we", we_cnt, 0);
        chk("stray_done", done_cnt + err_cnt, 0);

        // Zero-wait refill of 0x1008.
        run_refill(32'h0000_1008, 0, 0);
        if (CWF) begin
            chk_addrs("line1008", 32'h1008, 32'h100C, 32'h1000, 32'h1004);
            chk_idx("line1008", 2, 3, 0, 1);
        end else begin
            chk_addrs("line1008", 32'h1000, 32'h1004, 32'h1008, 32'h100C);
            chk_idx("line1008", 0, 1, 2, 3);
        end
        chk("zero_wait_latency", done_cyc - acc_cyc, 5);
        chk("zero_wait_done_cnt", done_cnt, 1);

        // Three wait cycles per beat.
        run_refill(32'h0000_3040, 3, 0);
        chk("wait_we_cnt", we_cnt, 4);
        chk("wait_latency", done_cyc - acc_cyc, 17);
        chk("wait_done_cnt", done_cnt, 1);

        // Error together with ack on the second beat.
        run_refill(32'h0000_4000, 0, 2);
        chk("err_we_cnt", we_cnt, 1);
        chk("err_err_cnt", err_cnt, 1);
        chk("err_done_cnt", done_cnt, 0);
        @(negedge clk); #1;
        chk("err_then_rdy", req_rdy_o, 1);

        // Reset right after the first ack.
        clear_logs();
        wait_cfg = 0; err_beat = 0; rsp_beat = 0;
        @(posedge clk); #1;
        req_vld = 1'b1; req_addr = 32'h0000_5000;
        @(posedge clk); #1;
        req_vld = 1'b0;
        for (i = 0; i < 50 && we_cnt == 0; i++) begin
            @(negedge clk); #1;
        end
        chk("rst_first_ack_seen", we_cnt, 1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk); #1;
        chk("rst_mid_stb", mem_stb_o, 0);
        chk("rst_mid_rdy", req_rdy_o, 1);
        repeat (6) @(negedge clk);
        #1;
        chk("rst_mid_no_pulse", done_cnt + err_cnt, 0);

        // Request held high through a refill with a second address queued behind it.
        clear_logs();
        rsp_beat = 0;
        acc0 = m_acc;
        @(posedge clk); #1;
        req_vld = 1'b1; req_addr = 32'h0000_1000;
        @(posedge clk); #1;
        req_addr = 32'h0000_2000;
        for (i = 0; i < 50 && m_acc < acc0 + 2; i++) begin
            @(negedge clk); #1;
        end
        chk("held_accepts", m_acc - acc0, 2);
        chk("held_done_before", done_cnt, 1);
        chk("held_accept_gap", acc_cyc - done_cyc, 1);
        clear_logs();
        @(posedge clk); #1 req_vld = 1'b0;
        wait_end(200);
        chk_addrs("line2000", 32'h2000, 32'h2004, 32'h2008, 32'h200C);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/cache_refill.md
CACHE_REFILL -- requirements
Module: cache_refill

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the request and memory address width in bits.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the memory word width in bits; it SHALL be a power of two and at least 8.
REQ-003 The block SHALL have parameter LINE_WORDS, default 4, meaning the words per cache line; it SHALL be a power of two and at least 2.
REQ-004 The block SHALL have these ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- req_vld_i  in  1  miss request valid.
- req_rdy_o  out  1  refill engine ready for a request.
- req_addr_i  in  ADDR_WIDTH  missing byte address.
- mem_stb_o  out  1  memory read beat request.
- mem_addr_o  out  ADDR_WIDTH  word-aligned beat address.
- mem_ack_i  in  1  beat complete, data valid.
- mem_err_i  in  1  beat failed.
- mem_data_i  in  DATA_WIDTH  read data.
- fill_we_o  out  1  line-array word write enable.
- fill_idx_o  out  clog2(LINE_WORDS)  word index within the line.
- fill_data_o  out  DATA_WIDTH  word to write.
- done_o  out  1  refill finished (one-cycle pulse).
- err_o  out  1  refill aborted (one-cycle pulse).

Function
REQ-005 The block SHALL have three states: IDLE, FETCH and DONE.
REQ-006 req_rdy_o SHALL be 1 only in IDLE.
REQ-007 In IDLE, a request is accepted when req_vld_i and req_rdy_o are both 1; on acceptance the block SHALL latch req_addr_i and enter FETCH on the next cycle.
REQ-008 The line base SHALL be the latched address with its low clog2(LINE_WORDS*DATA_WIDTH/8) bits cleared.
REQ-009 mem_addr_o SHALL be the line base with the current word offset placed above the byte-offset bits; the byte-offset bits SHALL be 0.
REQ-010 In FETCH, mem_stb_o SHALL be 1 and only one beat SHALL be outstanding at a time.
REQ-011 While mem_stb_o is 1 and no ack or error has arrived, mem_addr_o SHALL hold stable for any number of wait cycles.
REQ-012 fill_we_o SHALL be combinational: it is 1 when the state is FETCH, mem_ack_i is 1 and mem_err_i is 0.
REQ-013 While fill_we_o is 1, fill_data_o SHALL equal mem_data_i and fill_idx_o SHALL equal the current offset.
REQ-014 Each ack in FETCH SHALL advance the offset by 1, modulo LINE_WORDS.
REQ-015 On the LINE_WORDS-th ack, the block SHALL enter DONE.
REQ-016 If mem_err_i is 1 in FETCH, the block SHALL enter DONE with an error flag set and SHALL make no further writes.
REQ-017 If mem_ack_i and mem_err_i are 1 in the same cycle, the error SHALL take priority and no write SHALL occur.
REQ-018 In DONE, the block SHALL pulse done_o (no error) or err_o (error), never both, and SHALL return to IDLE on the next cycle.
REQ-019 Requests presented while the block is in FETCH or DONE SHALL NOT be accepted; the requester holds req_vld_i.
REQ-020 Latency: with zero-wait memory, done_o SHALL assert LINE_WORDS+1 cycles after the acceptance cycle.
REQ-021 mem_ack_i and mem_err_i SHALL be ignored outside FETCH.

Reset
REQ-022 Reset SHALL force state to IDLE and clear the offset, error flag and latched address.
REQ-023 During reset and in the cycle after it: req_rdy_o=1, and mem_stb_o, fill_we_o, done_o and err_o are 0.
REQ-024 Reset asserted in the middle of FETCH SHALL abandon the refill without a done_o or err_o pulse.

Configuration
REQ-025 The block SHALL support macro CACHE_REFILL_CWF_EN.
REQ-026 With CACHE_REFILL_CWF_EN defined, the starting offset SHALL be the word offset of req_addr_i, and the offset SHALL wrap modulo LINE_WORDS (critical word first).
REQ-027 Without CACHE_REFILL_CWF_EN, the starting offset SHALL always be 0.

Structure
REQ-028 Package cache_pkg SHALL hold the refill_state_t enum (IDLE, FETCH, DONE) and the line-geometry localparams (word offset width, byte offset width).
REQ-029 Sub-module cache_refill_wrapctr SHALL implement the loadable modulo-LINE_WORDS offset counter and the beat count.
REQ-030 No other sub-module SHALL be used.

Verification
REQ-031 The bench SHALL cover these scenarios, with LINE_WORDS=4 and DATA_WIDTH=32:
- No CWF, request 0x0000_1008, ack every cycle -> mem_addr_o = 0x1000, 0x1004, 0x1008, 0x100C; fill_idx_o = 0,1,2,3; done_o pulses at cycle 5.
- CWF_EN, request 0x0000_1008 -> mem_addr_o = 0x1008, 0x100C, 0x1000, 0x1004; fill_idx_o = 2,3,0,1; done_o pulses once.
- 3 wait cycles per beat -> mem_stb_o and mem_addr_o are stable across the waits; exactly 4 fill_we_o pulses; done_o at cycle 17.
- mem_err_i on the 2nd beat, with mem_ack_i also 1 -> exactly 1 fill write, err_o pulses, no done_o, req_rdy_o=1 the following cycle.
- Reset asserted after the 1st ack -> mem_stb_o=0 and req_rdy_o=1 the next cycle; no done_o or err_o.
- req_vld_i held high through the refill with a second address 0x2000 -> it is accepted only in the IDLE cycle after DONE; second refill fetches 0x2000 through 0x200C.
